// File: rtl/ula_pkg.sv
// ============================================================================
//  Module      : ula_pkg
//  Description : Shared opcodes, instruction field positions and state
//                encoding for the ULA instruction controller.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package ula_pkg;

    localparam int DW   = 8;
    localparam int AW   = 3;
    localparam int NREG = 8;

    // Low bit of each instruction field; opcode/rd/rs/rt are 3 bits, imm is DW bits
    localparam int OPC_LO = 13;
    localparam int RD_LO  = 10;
    localparam int RS_LO  = 7;
    localparam int RT_LO  = 4;
    localparam int IMM_LO = 0;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CAPT  = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_NOT, OP_SLT: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_ctrl_regfile.sv
// ============================================================================
//  Module      : ula_ctrl_regfile
//  Description : 8x8 register file, one synchronous write port, two
//                combinational operand reads and a combinational debug read.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ula_ctrl_regfile
    import ula_pkg::*;
(
    input  logic          clk,
    input  logic          clr,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

`default_nettype wire

// File: rtl/ula_ctrl.sv
// ============================================================================
//  Module      : ula_ctrl
//  Description : Instruction issuer / writeback controller for the 8-bit ULA.
//                Optional flag outputs enabled by ULA_CTRL_FLAGS_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ula_ctrl
    import ula_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    output logic          wb_valid,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
`ifdef ULA_CTRL_FLAGS_EN
    ,
    output logic          flag_z,
    output logic          flag_n
`endif
);

    state_t        r_state;
    logic [1:0]    r_cnt;
    logic [AW-1:0] r_rd;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic          r_wb_valid;
    logic [AW-1:0] r_wb_addr;
    logic [DW-1:0] r_wb_data;

    logic [2:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs;
    logic [AW-1:0] w_rt;
    logic [DW-1:0] w_imm;
    logic          w_accept;
    logic          w_capt;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [DW-1:0] w_rdata_a;
    logic [DW-1:0] w_rdata_b;

    assign w_op     = instr[OPC_LO +: 3];
    assign w_rd     = instr[RD_LO  +: AW];
    assign w_rs     = instr[RS_LO  +: AW];
    assign w_rt     = instr[RT_LO  +: AW];
    assign w_imm    = instr[IMM_LO +: DW];

    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_capt   = (r_state == ST_CAPT);

    // One write port shared by ALU capture and LDI; they can never coincide
    assign w_we     = w_capt || (w_accept && (w_op == OP_LDI));
    assign w_waddr  = w_capt ? r_rd : w_rd;
    assign w_wdata  = w_capt ? alu_result : w_imm;

    ula_ctrl_regfile u_regfile (
        .clk        (clk),
        .clr        (clr),
        .i_we       (w_we),
        .i_waddr    (w_waddr),
        .i_wdata    (w_wdata),
        .i_raddr_a  (w_rs),
        .i_raddr_b  (w_rt),
        .i_dbg_addr (dbg_addr),
        .o_rdata_a  (w_rdata_a),
        .o_rdata_b  (w_rdata_b),
        .o_dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_addr <= w_waddr;
                r_wb_data <= w_wdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && is_alu_op(w_op)) begin
                        r_alu_op <= w_op;
                        r_alu_a  <= w_rdata_a;
                        r_alu_b  <= (w_op == OP_NOT) ? '0 : w_rdata_b;
                        r_rd     <= w_rd;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ALU_LAT > 1) begin
                        r_cnt   <= 2'(ALU_LAT - 2);
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= ST_CAPT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state <= ST_CAPT;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_CAPT: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign wb_valid    = r_wb_valid;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;

`ifdef ULA_CTRL_FLAGS_EN
    logic r_flag_z;
    logic r_flag_n;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
        end else if (w_we) begin
            r_flag_z <= (w_wdata == '0);
            r_flag_n <= w_wdata[DW-1];
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ula_ctrl.sv
// ============================================================================
//  Module      : tb_ula_ctrl
//  Description : Directed bench for ula_ctrl at ALU_LAT=1 and ALU_LAT=3.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ula_ctrl;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    // ALU_LAT = 1 instance
    logic        v1, rdy1, wbv1;
    logic [15:0] i1;
    logic [2:0]  op1, wba1, dba1;
    logic [7:0]  a1, b1, res1, wbd1, dbd1;
    // ALU_LAT = 3 instance
    logic        v3, rdy3, wbv3;
    logic [15:0] i3;
    logic [2:0]  op3, wba3, dba3;
    logic [7:0]  a3, b3, res3, wbd3, dbd3, p3a, p3b;
`ifdef ULA_CTRL_FLAGS_EN
    logic fz1, fn1, fz3, fn3;
`endif

    ula_ctrl #(.ALU_LAT(1)) dut1 (
        .clk(clk), .clr(clr), .instr_valid(v1), .instr(i1), .instr_ready(rdy1),
        .alu_op(op1), .alu_a(a1), .alu_b(b1), .alu_result(res1),
        .wb_valid(wbv1), .wb_addr(wba1), .wb_data(wbd1),
        .dbg_addr(dba1), .dbg_data(dbd1)
`ifdef ULA_CTRL_FLAGS_EN
        , .flag_z(fz1), .flag_n(fn1)
`endif
    );

    ula_ctrl #(.ALU_LAT(3)) dut3 (
        .clk(clk), .clr(clr), .instr_valid(v3), .instr(i3), .instr_ready(rdy3),
        .alu_op(op3), .alu_a(a3), .alu_b(b3), .alu_result(res3),
        .wb_valid(wbv3), .wb_addr(wba3), .wb_data(wbd3),
        .dbg_addr(dba3), .dbg_data(dbd3)
`ifdef ULA_CTRL_FLAGS_EN
        , .flag_z(fz3), .flag_n(fn3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA: registered, latency 1 and 3
    function automatic logic [7:0] ula_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a | b;
            3'b011:  return a & b;
            3'b100:  return ~a;
            3'b101:  return (a < b) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) res1 <= ula_f(op1, a1, b1);
    always_ff @(posedge clk) begin
        p3a  <= ula_f(op3, a3, b3);
        p3b  <= p3a;
        res3 <= p3b;
    end

    function automatic logic [15:0] rr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 4'b0000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {3'b110, rd, 2'b00, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ldi1(input logic [2:0] rd, input logic [7:0] imm);
        v1 = 1'b1; i1 = ldi(rd, imm); tick; v1 = 1'b0;
    endtask

    // Issue one ALU instruction on dut1 and return the writeback seen 3 cycles later
    task automatic run1(input logic [15:0] w, output logic wv, output logic [2:0] wa, output logic [7:0] wd);
        v1 = 1'b1; i1 = w; tick; v1 = 1'b0; tick; tick;
        wv = wbv1; wa = wba1; wd = wbd1;
    endtask

    task automatic test_reset;
        clr = 1'b1; v1 = 1'b0; v3 = 1'b0; i1 = '0; i3 = '0; dba1 = '0; dba3 = '0;
        tick; tick;
        clr = 1'b0;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b want 1", rdy1); end
        checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL reset_ready3 got %b want 1", rdy3); end
        checks++; if (wbv1 !== 1'b0) begin errors++; $display("FAIL reset_wbv got %b want 0", wbv1); end
        checks++; if ({op1, a1, b1} !== 19'h0) begin errors++; $display("FAIL reset_alu got %h want 0", {op1, a1, b1}); end
        checks++; if ({wba1, wbd1} !== 11'h0) begin errors++; $display("FAIL reset_wb got %h want 0", {wba1, wbd1}); end
    endtask

    task automatic test_reset_mid_issue;
        ldi1(3'd1, 8'h05);
        checks++; if (wbv1 !== 1'b1 || wbd1 !== 8'h05) begin errors++; $display("FAIL mid_ldi got v=%b d=%h want v=1 d=05", wbv1, wbd1); end
        v1 = 1'b1; i1 = rr(3'b000, 3'd3, 3'd1, 3'd1); tick; v1 = 1'b0;
        checks++; if (rdy1 !== 1'b0 || a1 !== 8'h05) begin errors++; $display("FAIL mid_issue got rdy=%b a=%h want rdy=0 a=05", rdy1, a1); end
        clr = 1'b1; tick;
        checks++; if (wbv1 !== 1'b0) begin errors++; $display("FAIL mid_clr_wbv got %b want 0", wbv1); end
        tick; clr = 1'b0;
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b want 1", rdy1); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (wbv1 !== 1'b0) begin errors++; $display("FAIL mid_dropped_wb cycle %0d got %b want 0", k, wbv1); end
        end
        for (int r = 0; r < 8; r++) begin
            dba1 = 3'(r); #1;
            checks++; if (dbd1 !== 8'h00) begin errors++; $display("FAIL mid_dbg r%0d got %h want 00", r, dbd1); end
        end
    endtask

    task automatic test_ldi_add;
        ldi1(3'd1, 8'h05);
        checks++; if ({wbv1, wba1, wbd1} !== {1'b1, 3'd1, 8'h05}) begin errors++; $display("FAIL ldi_r1 got %h want %h", {wbv1, wba1, wbd1}, {1'b1, 3'd1, 8'h05}); end
        ldi1(3'd2, 8'h03);
        checks++; if ({wbv1, wba1, wbd1} !== {1'b1, 3'd2, 8'h03}) begin errors++; $display("FAIL ldi_r2 got %h want %h", {wbv1, wba1, wbd1}, {1'b1, 3'd2, 8'h03}); end
        dba1 = 3'd3;
        v1 = 1'b1; i1 = rr(3'b000, 3'd3, 3'd1, 3'd2); tick; v1 = 1'b0;
        checks++; if ({rdy1, op1, a1, b1} !== {1'b0, 3'b000, 8'h05, 8'h03}) begin errors++; $display("FAIL add_issue got %h want %h", {rdy1, op1, a1, b1}, {1'b0, 3'b000, 8'h05, 8'h03}); end
        checks++; if (wbv1 !== 1'b0) begin errors++; $display("FAIL add_no_early_wb got %b want 0", wbv1); end
        tick;
        checks++; if (wbv1 !== 1'b0 || dbd1 !== 8'h00) begin errors++; $display("FAIL add_capt got v=%b dbg=%h want v=0 dbg=00", wbv1, dbd1); end
        tick;
        checks++; if ({wbv1, wba1, wbd1} !== {1'b1, 3'd3, 8'h08}) begin errors++; $display("FAIL add_wb got %h want %h", {wbv1, wba1, wbd1}, {1'b1, 3'd3, 8'h08}); end
        checks++; if (dbd1 !== 8'h08 || rdy1 !== 1'b1) begin errors++; $display("FAIL add_after got dbg=%h rdy=%b want dbg=08 rdy=1", dbd1, rdy1); end
        tick;
        checks++; if (wbv1 !== 1'b0) begin errors++; $display("FAIL add_pulse_width got %b want 0", wbv1); end
    endtask

    task automatic test_sub_slt;
        logic       wv;
        logic [2:0] wa;
        logic [7:0] wd;
        run1(rr(3'b001, 3'd4, 3'd2, 3'd1), wv, wa, wd);
        checks++; if ({wv, wa, wd} !== {1'b1, 3'd4, 8'hFE}) begin errors++; $display("FAIL sub got %h want %h", {wv, wa, wd}, {1'b1, 3'd4, 8'hFE}); end
        run1(rr(3'b101, 3'd5, 3'd2, 3'd1), wv, wa, wd);
        checks++; if ({wv, wa, wd} !== {1'b1, 3'd5, 8'h01}) begin errors++; $display("FAIL slt_true got %h want %h", {wv, wa, wd}, {1'b1, 3'd5, 8'h01}); end
        run1(rr(3'b101, 3'd5, 3'd1, 3'd2), wv, wa, wd);
        checks++; if ({wv, wa, wd} !== {1'b1, 3'd5, 8'h00}) begin errors++; $display("FAIL slt_false got %h want %h", {wv, wa, wd}, {1'b1, 3'd5, 8'h00}); end
    endtask

    task automatic test_logic;
        logic       wv;
        logic [2:0] wa;
        logic [7:0] wd;
        ldi1(3'd1, 8'h0F);
        v1 = 1'b1; i1 = rr(3'b100, 3'd6, 3'd1, 3'd2); tick; v1 = 1'b0;
        checks++; if ({op1, a1, b1} !== {3'b100, 8'h0F, 8'h00}) begin errors++; $display("FAIL not_issue got %h want %h", {op1, a1, b1}, {3'b100, 8'h0F, 8'h00}); end
        tick; tick;
        checks++; if ({wbv1, wba1, wbd1} !== {1'b1, 3'd6, 8'hF0}) begin errors++; $display("FAIL not_wb got %h want %h", {wbv1, wba1, wbd1}, {1'b1, 3'd6, 8'hF0}); end
        run1(rr(3'b010, 3'd7, 3'd1, 3'd6), wv, wa, wd);
        checks++; if ({wv, wa, wd} !== {1'b1, 3'd7, 8'hFF}) begin errors++; $display("FAIL or got %h want %h", {wv, wa, wd}, {1'b1, 3'd7, 8'hFF}); end
        run1(rr(3'b011, 3'd7, 3'd1, 3'd6), wv, wa, wd);
        checks++; if ({wv, wa, wd} !== {1'b1, 3'd7, 8'h00}) begin errors++; $display("FAIL and got %h want %h", {wv, wa, wd}, {1'b1, 3'd7, 8'h00}); end
        dba1 = 3'd6; #1;
        checks++; if (dbd1 !== 8'hF0) begin errors++; $display("FAIL dbg_r6 got %h want F0", dbd1); end
    endtask

    task automatic test_back_to_back;
        v3 = 1'b1; i3 = ldi(3'd1, 8'h05); tick;
        i3 = ldi(3'd2, 8'h03); tick;
        checks++; if ({wbv3, wba3, wbd3} !== {1'b1, 3'd2, 8'h03}) begin errors++; $display("FAIL b2b_ldi got %h want %h", {wbv3, wba3, wbd3}, {1'b1, 3'd2, 8'h03}); end
        i3 = rr(3'b000, 3'd3, 3'd1, 3'd2); tick;
        i3 = rr(3'b001, 3'd4, 3'd2, 3'd1);
        for (int k = 0; k < 4; k++) begin
            checks++; if ({rdy3, wbv3, op3, a3, b3} !== {1'b0, 1'b0, 3'b000, 8'h05, 8'h03}) begin errors++; $display("FAIL b2b_add_hold cycle %0d got %h want %h", k, {rdy3, wbv3, op3, a3, b3}, {1'b0, 1'b0, 3'b000, 8'h05, 8'h03}); end
            tick;
        end
        checks++; if ({rdy3, wbv3, wba3, wbd3} !== {1'b1, 1'b1, 3'd3, 8'h08}) begin errors++; $display("FAIL b2b_add_wb got %h want %h", {rdy3, wbv3, wba3, wbd3}, {1'b1, 1'b1, 3'd3, 8'h08}); end
        tick;
        i3 = 16'hE000;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({rdy3, wbv3, op3, a3, b3} !== {1'b0, 1'b0, 3'b001, 8'h03, 8'h05}) begin errors++; $display("FAIL b2b_sub_hold cycle %0d got %h want %h", k, {rdy3, wbv3, op3, a3, b3}, {1'b0, 1'b0, 3'b001, 8'h03, 8'h05}); end
            tick;
        end
        checks++; if ({rdy3, wbv3, wba3, wbd3} !== {1'b1, 1'b1, 3'd4, 8'hFE}) begin errors++; $display("FAIL b2b_sub_wb got %h want %h", {rdy3, wbv3, wba3, wbd3}, {1'b1, 1'b1, 3'd4, 8'hFE}); end
        tick;
        for (int k = 0; k < 3; k++) begin
            checks++; if ({rdy3, wbv3} !== 2'b10) begin errors++; $display("FAIL b2b_nop cycle %0d got rdy/wbv=%b want 10", k, {rdy3, wbv3}); end
            tick;
        end
        v3 = 1'b0;
        dba3 = 3'd4; #1;
        checks++; if (dbd3 !== 8'hFE) begin errors++; $display("FAIL b2b_dbg_r4 got %h want FE", dbd3); end
    endtask

`ifdef ULA_CTRL_FLAGS_EN
    task automatic test_flags;
        logic       wv;
        logic [2:0] wa;
        logic [7:0] wd;
        ldi1(3'd1, 8'h05);
        checks++; if ({fz1, fn1} !== 2'b00) begin errors++; $display("FAIL flags_ldi5 got z/n=%b want 00", {fz1, fn1}); end
        run1(rr(3'b001, 3'd0, 3'd1, 3'd1), wv, wa, wd);
        checks++; if ({wd, fz1, fn1} !== {8'h00, 2'b10}) begin errors++; $display("FAIL flags_sub0 got %h want %h", {wd, fz1, fn1}, {8'h00, 2'b10}); end
        ldi1(3'd0, 8'h80);
        checks++; if ({fz1, fn1} !== 2'b01) begin errors++; $display("FAIL flags_ldi80 got z/n=%b want 01", {fz1, fn1}); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_reset_mid_issue;
        test_ldi_add;
        test_sub_slt;
        test_logic;
        test_back_to_back;
`ifdef ULA_CTRL_FLAGS_EN
        test_flags;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
- Instruction issuer and writeback controller on the driving side of the 8-bit ULA operation units (add, sub, or, and, not, slt).
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 8x8 register file and drives opcode and operands to the ULA.
- Waits the ULA's registered latency, captures the result, writes it back and reports a writeback pulse.

Parameters:
- ALU_LAT, 1: clock edges between the ULA sampling its operands and its result being stable (range 1..4).
- NREG, 8: register file depth; fixed at 8 because the instruction fields are 3 bits wide.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr  in  1  synchronous active-high reset.
- instr_valid  in  1  instruction word present.
- instr  in  16  instruction word.
- instr_ready  out  1  controller can accept an instruction.
- alu_op  out  3  opcode to the ULA.
- alu_a  out  8  operand 1.
- alu_b  out  8  operand 2.
- alu_result  in  8  registered ULA result.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_addr  out  3  destination register written.
- wb_data  out  8  value written.
- dbg_addr  in  3  debug read address.
- dbg_data  out  8  combinational read of the register file at dbg_addr.

Behaviour:
- Reset: clk and clr are the only clock and reset. Reset is synchronous, active-high. When clr=1 at a posedge:
  - state becomes IDLE;
  - all registers, alu_op, alu_a, alu_b, wb_addr and wb_data become 0;
  - wb_valid becomes 0 and instr_ready becomes 1 in the following cycle.
  - An in-flight instruction is dropped with no writeback.
- Instruction format:
  - [15:13] opcode; [12:10] rd; [9:7] rs; [6:4] rt; [7:0] imm8 (LDI only).
  - Opcodes: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 NOT (rs only; alu_b driven 0), 101 SLT (unsigned), 110 LDI, 111 NOP.
- States: IDLE, ISSUE, WAIT, CAPT.
  - IDLE: instr_ready=1. Accept on instr_valid&instr_ready at edge E0.
    - ALU ops go to ISSUE.
    - LDI writes rf[rd]=imm8 at E0; wb_valid pulses in the next cycle; stay in IDLE.
    - NOP: no effect, stay in IDLE.
  - ISSUE: instr_ready=0. alu_op=opcode, alu_a=rf[rs], alu_b=rf[rt], all registered and set at E0. ULA samples at E1. Next state is WAIT if ALU_LAT>1, else CAPT.
  - WAIT: counter runs ALU_LAT-1 cycles, then goes to CAPT.
  - CAPT: at the closing edge, rf[rd]<=alu_result, wb_valid<=1, wb_addr<=rd, wb_data<=alu_result; next state IDLE.
- alu_op, alu_a and alu_b hold stable from ISSUE through CAPT, because the ULA re-samples every edge.
- Latency:
  - ALU instruction accepted at E0 -> wb_valid high in the cycle after edge E(1+ALU_LAT), i.e. 3 cycles for ALU_LAT=1.
  - Throughput is one ALU instruction per 2+ALU_LAT cycles.
- wb_valid is high for exactly one cycle. instr_ready is already 1 in that cycle, so back-to-back acceptance is allowed.
- dbg_data shows the pre-write value during the write edge's cycle and the new value after it.
- Arithmetic wraps modulo 256; the controller does no width extension.
- instr is ignored while instr_ready=0. The source must hold instr stable until accepted.

Optional Feature:
- Macro ULA_CTRL_FLAGS_EN.
- When defined:
  - adds outputs flag_z (1) and flag_n (1), registered and updated on each writeback (ALU or LDI);
  - flag_z = (wb_data==0); flag_n = wb_data[7];
  - both reset to 0.
- When undefined: the ports are absent and there is no flag logic.

Decomposition:
- Shared package ula_pkg:
  - opcode constants (OP_ADD..OP_NOP);
  - instruction field bit positions;
  - state encoding;
  - data width 8 and register address width 3.
- One natural sub-module: ula_ctrl_regfile, 8x8, one synchronous write port, two combinational read ports plus the debug port, synchronous clear on clr.

Test Plan:
- Reset: clr=1 for 2 cycles mid-ISSUE of ADD -> no wb_valid; dbg_data=0 for all addresses; instr_ready=1 after release.
- LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 with ALU_LAT=1 and a registered adder model -> wb_valid 3 cycles after ADD acceptance; wb_addr=3, wb_data=0x08; dbg_addr=3 reads 0x08.
- SUB r4,r2,r1 (3-5) -> wb_data=0xFE; SLT r5,r2,r1 -> 0x01; SLT r5,r1,r2 -> 0x00.
- NOT r6,r1 with r1=0x0F -> alu_b=0, wb_data=0xF0; OR r7,r1,r6 -> 0xFF; AND r7,r1,r6 -> 0x00.
- ALU_LAT=3: instr_valid held high continuously -> instr_ready low for 4 cycles per ALU instruction; operands stable throughout; NOP is accepted with no wb_valid.
- ULA_CTRL_FLAGS_EN defined: SUB yielding 0x00 -> flag_z=1, flag_n=0; then LDI 0x80 -> flag_z=0, flag_n=1.
